// File: rtl/tc_shared_delay_ctrl.sv
// Round-robin shared down-counter: grants one requester, loads its delay, pulses done after D+1 edges.
// All outputs registered; req is ignored while a delay runs, so waiting requesters simply hold req.
module tc_shared_delay_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] delay,
  input  logic                         abort,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [IDX_W-1:0]             owner,
  output logic [BIT_WIDTH-1:0]         count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [BIT_WIDTH-1:0] count_q, count_d;

  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic [BIT_WIDTH-1:0] grant_delay;

  // Scan starts one past the last winner so every requester is served before any repeats.
  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = '0;
    grant_delay = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_vld && req[j]) begin
        grant_vld   = 1'b1;
        grant_idx   = IDX_W'(j);
        grant_delay = delay[j*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    done_d  = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (grant_vld && !abort) begin
          state_d            = RUN;
          owner_d            = grant_idx;
          ptr_d              = grant_idx;
          count_d            = grant_delay;
          ack_d[grant_idx]   = 1'b1;
        end
      end
      RUN: begin
        // Abort wins over expiry and leaves count frozen at its current value.
        if (abort) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= '0;
      done_q  <= '0;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign ack   = ack_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN);
  assign owner = owner_q;
  assign count = count_q;

endmodule

// File: doc/tc_shared_delay_ctrl.md
Name: tc_shared_delay_ctrl

Overview:
Arbitrated controller that shares one down-counting delay counter among NUM_REQ requesters.
- Each requester asks for a delay of D cycles.
- The controller grants the counter round-robin, loads D, counts down, and pulses a per-requester done when the delay expires.
- It sits between scheduling logic (sequencers, bus wait-state generators) and a single counter resource.

Parameters:
- BIT_WIDTH, 8, width of the delay value and the counter.
- NUM_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(NUM_REQ), width of the owner index (derived; do not override).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_REQ  per-requester request level.
- delay  input  NUM_REQ*BIT_WIDTH  flat delay values; requester i uses bits [i*BIT_WIDTH +: BIT_WIDTH].
- abort  input  1  synchronous cancel of the running delay.
- ack  output  NUM_REQ  one-cycle grant pulse, one-hot or zero.
- done  output  NUM_REQ  one-cycle expiry pulse, one-hot or zero.
- busy  output  1  high while a delay is running.
- owner  output  IDX_W  index of the current or last granted requester.
- count  output  BIT_WIDTH  remaining count of the running delay.

Behaviour:
- Reset (async): state=IDLE, ack=0, done=0, busy=0, owner=0, count=0, rr pointer=NUM_REQ-1 (req[0] wins first).
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, RUN. busy = (state==RUN).
- IDLE, at an edge with |req and !abort:
  - winner = first i with req[i]=1, scanning ptr+1, ptr+2, … modulo NUM_REQ.
  - Next state: RUN, owner<=winner, ptr<=winner, count<=delay[winner], ack[winner]<=1 for exactly one cycle.
- IDLE with abort=1: no grant that cycle; abort is otherwise ignored.
- RUN, at each edge:
  - abort=1 -> IDLE; no done pulse; count holds its value.
  - else if count==0 -> done[owner]<=1 for one cycle, state<=IDLE.
  - else count<=count-1.
  - abort has priority over expiry in the same cycle.
- Latency:
  - done rises D+1 edges after ack rises.
  - D=0 gives done in the cycle immediately after the ack cycle.
  - Maximum D = 2^BIT_WIDTH-1. No wrap: the counter never decrements below 0.
- Requester protocol:
  - Hold req and delay stable until ack is seen, then drop req in the ack cycle.
  - req is not sampled in RUN, so new or held requests wait.
  - After done, the earliest next grant is the edge following the done cycle (IDLE lasts at least one cycle between delays).
  - A req still high in IDLE after its own done is treated as a new request.
- delay is sampled only at the grant edge. Later changes have no effect on the running delay.
- ack and done are never high in the same cycle.
- owner holds its value in IDLE.
- Reset mid-RUN: everything returns to reset values immediately; no done is emitted.

Test Plan:
- Single request:
  - Stimulus: req=0001, delay[0]=3, drop req on ack.
  - Required: ack=0001 for 1 cycle; count goes 3,2,1,0; done=0001 exactly 4 edges after ack rises; busy high from ack to done; owner=0.
- Zero delay:
  - Stimulus: req[2] with delay=0.
  - Required: done=0100 in the cycle right after ack; next grant no earlier than 2 edges later.
- Round-robin:
  - Stimulus: req=1111 held; each requester re-raises req after its done; all delays=1.
  - Required: grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Abort:
  - Stimulus: req[1], delay=10; assert abort when count=5.
  - Required: next cycle busy=0; done never pulses; next pending req granted the following edge.
- Abort on expiry edge:
  - Stimulus: abort asserted while count==0.
  - Required: no done, state IDLE.
- Async reset mid-RUN:
  - Stimulus: assert rst asynchronously when count=7.
  - Required: busy, ack, done, count and owner go to 0 immediately, without a clock edge; after release, req[3] alone is granted with owner=3.
